// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, next-PC select (jump > branch > stall > +4) and IF/ID pipeline register.
// Latency: one cycle from the imem_data presented for pc to id_instr/id_valid; imem_addr is combinational from pc.
// Backpressure: stall holds PC and IF/ID; redirects override stall for the PC, and redirects or flush override it with a bubble.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump_en,
    input  logic [31:0] jump_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic [31:0] pc,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc_plus4,
    output logic        id_valid,
    output logic [31:0] fetch_count
);

    logic [31:0] pc_q,          pc_d;
    logic [31:0] id_instr_q,    id_instr_d;
    logic [31:0] id_pc_plus4_q, id_pc_plus4_d;
    logic        id_valid_q,    id_valid_d;
    logic [31:0] fetch_count_q, fetch_count_d;

    logic [31:0] pc_plus4;
    logic        redirect;

    // Misaligned target bits are discarded silently; this only keeps them visibly consumed.
    logic unused_target_lsbs;
    assign unused_target_lsbs = ^{jump_target[1:0], branch_target[1:0]};

    assign pc_plus4  = pc_q + 32'd4;   // wraps modulo 2^32
    assign redirect  = jump_en | branch_taken;
    assign imem_addr = {2'b00, pc_q[31:2]};

    // Next-PC selection: jump wins over branch, either wins over stall.
    always_comb begin
        pc_d = pc_plus4;
        if (jump_en) begin
            pc_d = {jump_target[31:2], 2'b00};
        end else if (branch_taken) begin
            pc_d = {branch_target[31:2], 2'b00};
        end else if (stall) begin
            pc_d = pc_q;
        end
    end

    // IF/ID next state: bubble on redirect/flush, hold on stall, else capture the fetched word.
    always_comb begin
        id_instr_d    = imem_data;
        id_pc_plus4_d = pc_plus4;
        id_valid_d    = 1'b1;
        fetch_count_d = fetch_count_q + 32'd1;
        if (redirect || flush) begin
            id_instr_d    = 32'h0000_0000;
            id_pc_plus4_d = 32'h0000_0000;
            id_valid_d    = 1'b0;
            fetch_count_d = fetch_count_q;
        end else if (stall) begin
            id_instr_d    = id_instr_q;
            id_pc_plus4_d = id_pc_plus4_q;
            id_valid_d    = id_valid_q;
            fetch_count_d = fetch_count_q;
        end
    end

    // State registers with synchronous reset that overrides every other control.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            id_instr_q    <= 32'h0000_0000;
            id_pc_plus4_q <= 32'h0000_0000;
            id_valid_q    <= 1'b0;
            fetch_count_q <= 32'h0000_0000;
        end else begin
            pc_q          <= pc_d;
            id_instr_q    <= id_instr_d;
            id_pc_plus4_q <= id_pc_plus4_d;
            id_valid_q    <= id_valid_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign pc          = pc_q;
    assign id_instr    = id_instr_q;
    assign id_pc_plus4 = id_pc_plus4_q;
    assign id_valid    = id_valid_q;
    assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: memory word N returns 32'h1000_0000 + N.
// A second instance with RESET_PC = 32'hFFFF_FFFC covers PC wrap-around.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst, stall, flush, branch_taken, jump_en;
    logic [31:0] branch_target, jump_target;
    logic [31:0] imem_addr, imem_data, pc, id_instr, id_pc_plus4, fetch_count;
    logic        id_valid;

    logic        rst_w;
    logic [31:0] imem_addr_w, imem_data_w, pc_w, id_instr_w, id_pc_plus4_w, fetch_count_w;
    logic        id_valid_w;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign imem_data   = 32'h1000_0000 + imem_addr;
    assign imem_data_w = 32'h1000_0000 + imem_addr_w;

    fetch_stage #(.RESET_PC(32'h0000_0000)) u_dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump_en(jump_en), .jump_target(jump_target),
        .imem_addr(imem_addr), .imem_data(imem_data), .pc(pc),
        .id_instr(id_instr), .id_pc_plus4(id_pc_plus4),
        .id_valid(id_valid), .fetch_count(fetch_count)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk(clk), .rst(rst_w), .stall(1'b0), .flush(1'b0),
        .branch_taken(1'b0), .branch_target(32'h0),
        .jump_en(1'b0), .jump_target(32'h0),
        .imem_addr(imem_addr_w), .imem_data(imem_data_w), .pc(pc_w),
        .id_instr(id_instr_w), .id_pc_plus4(id_pc_plus4_w),
        .id_valid(id_valid_w), .fetch_count(fetch_count_w)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        branch_taken = 1'b0; jump_en = 1'b0;
        branch_target = 32'h0; jump_target = 32'h0;
        tick(); tick();
        n_vec++; if (pc !== 32'h0) begin n_err++; $display("FAIL reset_pc got %h exp %h", pc, 32'h0); end
        n_vec++; if (id_instr !== 32'h0) begin n_err++; $display("FAIL reset_instr got %h exp %h", id_instr, 32'h0); end
        n_vec++; if (id_pc_plus4 !== 32'h0) begin n_err++; $display("FAIL reset_pc4 got %h exp %h", id_pc_plus4, 32'h0); end
        n_vec++; if (id_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b exp 0", id_valid); end
        n_vec++; if (fetch_count !== 32'h0) begin n_err++; $display("FAIL reset_count got %h exp %h", fetch_count, 32'h0); end
        n_vec++; if (imem_addr !== 32'h0) begin n_err++; $display("FAIL reset_imem_addr got %h exp %h", imem_addr, 32'h0); end
        rst = 1'b0;
    endtask

    task automatic test_sequential();
        tick();
        n_vec++; if (pc !== 32'h4) begin n_err++; $display("FAIL seq1_pc got %h exp %h", pc, 32'h4); end
        n_vec++; if (id_instr !== 32'h1000_0000) begin n_err++; $display("FAIL seq1_instr got %h exp %h", id_instr, 32'h1000_0000); end
        n_vec++; if (id_pc_plus4 !== 32'h4) begin n_err++; $display("FAIL seq1_pc4 got %h exp %h", id_pc_plus4, 32'h4); end
        n_vec++; if (id_valid !== 1'b1) begin n_err++; $display("FAIL seq1_valid got %b exp 1", id_valid); end
        n_vec++; if (fetch_count !== 32'd1) begin n_err++; $display("FAIL seq1_count got %0d exp 1", fetch_count); end
        tick();
        n_vec++; if (pc !== 32'h8) begin n_err++; $display("FAIL seq2_pc got %h exp %h", pc, 32'h8); end
        n_vec++; if (id_instr !== 32'h1000_0001) begin n_err++; $display("FAIL seq2_instr got %h exp %h", id_instr, 32'h1000_0001); end
        n_vec++; if (id_pc_plus4 !== 32'h8) begin n_err++; $display("FAIL seq2_pc4 got %h exp %h", id_pc_plus4, 32'h8); end
        n_vec++; if (fetch_count !== 32'd2) begin n_err++; $display("FAIL seq2_count got %0d exp 2", fetch_count); end
        n_vec++; if (imem_addr !== 32'h2) begin n_err++; $display("FAIL seq2_imem_addr got %h exp %h", imem_addr, 32'h2); end
    endtask

    task automatic test_stall();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++; if (pc !== 32'h8) begin n_err++; $display("FAIL stall%0d_pc got %h exp %h", i, pc, 32'h8); end
            n_vec++; if (id_instr !== 32'h1000_0001) begin n_err++; $display("FAIL stall%0d_instr got %h exp %h", i, id_instr, 32'h1000_0001); end
            n_vec++; if (id_valid !== 1'b1) begin n_err++; $display("FAIL stall%0d_valid got %b exp 1", i, id_valid); end
            n_vec++; if (fetch_count !== 32'd2) begin n_err++; $display("FAIL stall%0d_count got %0d exp 2", i, fetch_count); end
        end
        stall = 1'b0;
        tick();
        n_vec++; if (pc !== 32'hC) begin n_err++; $display("FAIL unstall_pc got %h exp %h", pc, 32'hC); end
        n_vec++; if (id_instr !== 32'h1000_0002) begin n_err++; $display("FAIL unstall_instr got %h exp %h", id_instr, 32'h1000_0002); end
        n_vec++; if (id_pc_plus4 !== 32'hC) begin n_err++; $display("FAIL unstall_pc4 got %h exp %h", id_pc_plus4, 32'hC); end
        n_vec++; if (fetch_count !== 32'd3) begin n_err++; $display("FAIL unstall_count got %0d exp 3", fetch_count); end
        tick();
        n_vec++; if (pc !== 32'h10) begin n_err++; $display("FAIL unstall2_pc got %h exp %h", pc, 32'h10); end
        n_vec++; if (id_instr !== 32'h1000_0003) begin n_err++; $display("FAIL unstall2_instr got %h exp %h", id_instr, 32'h1000_0003); end
        n_vec++; if (fetch_count !== 32'd4) begin n_err++; $display("FAIL unstall2_count got %0d exp 4", fetch_count); end
    endtask

    task automatic test_redirect();
        jump_en = 1'b1; jump_target = 32'h40;
        branch_taken = 1'b1; branch_target = 32'h80;
        stall = 1'b1;
        tick();
        jump_en = 1'b0; branch_taken = 1'b0; stall = 1'b0;
        n_vec++; if (pc !== 32'h40) begin n_err++; $display("FAIL prio_pc got %h exp %h", pc, 32'h40); end
        n_vec++; if (id_valid !== 1'b0) begin n_err++; $display("FAIL prio_valid got %b exp 0", id_valid); end
        n_vec++; if (id_instr !== 32'h0) begin n_err++; $display("FAIL prio_instr got %h exp %h", id_instr, 32'h0); end
        n_vec++; if (id_pc_plus4 !== 32'h0) begin n_err++; $display("FAIL prio_pc4 got %h exp %h", id_pc_plus4, 32'h0); end
        n_vec++; if (fetch_count !== 32'd4) begin n_err++; $display("FAIL prio_count got %0d exp 4", fetch_count); end
        branch_taken = 1'b1; branch_target = 32'h0000_0107;
        tick();
        branch_taken = 1'b0;
        n_vec++; if (pc !== 32'h104) begin n_err++; $display("FAIL misalign_pc got %h exp %h", pc, 32'h104); end
        n_vec++; if (imem_addr !== 32'h41) begin n_err++; $display("FAIL misalign_imem_addr got %h exp %h", imem_addr, 32'h41); end
        n_vec++; if (id_valid !== 1'b0) begin n_err++; $display("FAIL branch_valid got %b exp 0", id_valid); end
        tick();
        n_vec++; if (pc !== 32'h108) begin n_err++; $display("FAIL post_branch_pc got %h exp %h", pc, 32'h108); end
        n_vec++; if (id_instr !== 32'h1000_0041) begin n_err++; $display("FAIL post_branch_instr got %h exp %h", id_instr, 32'h1000_0041); end
        n_vec++; if (id_pc_plus4 !== 32'h108) begin n_err++; $display("FAIL post_branch_pc4 got %h exp %h", id_pc_plus4, 32'h108); end
        n_vec++; if (fetch_count !== 32'd5) begin n_err++; $display("FAIL post_branch_count got %0d exp 5", fetch_count); end
    endtask

    task automatic test_flush();
        flush = 1'b1;
        tick();
        n_vec++; if (pc !== 32'h10C) begin n_err++; $display("FAIL flush_pc got %h exp %h", pc, 32'h10C); end
        n_vec++; if (id_valid !== 1'b0) begin n_err++; $display("FAIL flush_valid got %b exp 0", id_valid); end
        n_vec++; if (id_instr !== 32'h0) begin n_err++; $display("FAIL flush_instr got %h exp %h", id_instr, 32'h0); end
        n_vec++; if (fetch_count !== 32'd5) begin n_err++; $display("FAIL flush_count got %0d exp 5", fetch_count); end
        flush = 1'b0;
        tick();
        stall = 1'b1; flush = 1'b1;
        tick();
        stall = 1'b0; flush = 1'b0;
        n_vec++; if (pc !== 32'h110) begin n_err++; $display("FAIL flush_stall_pc got %h exp %h", pc, 32'h110); end
        n_vec++; if (id_valid !== 1'b0) begin n_err++; $display("FAIL flush_stall_valid got %b exp 0", id_valid); end
        n_vec++; if (fetch_count !== 32'd6) begin n_err++; $display("FAIL flush_stall_count got %0d exp 6", fetch_count); end
    endtask

    task automatic test_reset_mid();
        jump_en = 1'b1; jump_target = 32'h20;
        tick();
        n_vec++; if (pc !== 32'h20) begin n_err++; $display("FAIL mid_setup_pc got %h exp %h", pc, 32'h20); end
        jump_target = 32'h40;
        rst = 1'b1; stall = 1'b1; flush = 1'b1;
        tick();
        rst = 1'b0; stall = 1'b0; flush = 1'b0; jump_en = 1'b0;
        n_vec++; if (pc !== 32'h0) begin n_err++; $display("FAIL mid_rst_pc got %h exp %h", pc, 32'h0); end
        n_vec++; if (id_instr !== 32'h0) begin n_err++; $display("FAIL mid_rst_instr got %h exp %h", id_instr, 32'h0); end
        n_vec++; if (id_pc_plus4 !== 32'h0) begin n_err++; $display("FAIL mid_rst_pc4 got %h exp %h", id_pc_plus4, 32'h0); end
        n_vec++; if (id_valid !== 1'b0) begin n_err++; $display("FAIL mid_rst_valid got %b exp 0", id_valid); end
        n_vec++; if (fetch_count !== 32'd0) begin n_err++; $display("FAIL mid_rst_count got %0d exp 0", fetch_count); end
        tick();
        n_vec++; if (pc !== 32'h4) begin n_err++; $display("FAIL after_rst_pc got %h exp %h", pc, 32'h4); end
        n_vec++; if (id_instr !== 32'h1000_0000) begin n_err++; $display("FAIL after_rst_instr got %h exp %h", id_instr, 32'h1000_0000); end
        n_vec++; if (fetch_count !== 32'd1) begin n_err++; $display("FAIL after_rst_count got %0d exp 1", fetch_count); end
    endtask

    task automatic test_wrap();
        rst_w = 1'b1;
        tick();
        n_vec++; if (pc_w !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_reset_pc got %h exp %h", pc_w, 32'hFFFF_FFFC); end
        n_vec++; if (imem_addr_w !== 32'h3FFF_FFFF) begin n_err++; $display("FAIL wrap_imem_addr got %h exp %h", imem_addr_w, 32'h3FFF_FFFF); end
        rst_w = 1'b0;
        tick();
        n_vec++; if (pc_w !== 32'h0) begin n_err++; $display("FAIL wrap_pc got %h exp %h", pc_w, 32'h0); end
        n_vec++; if (id_pc_plus4_w !== 32'h0) begin n_err++; $display("FAIL wrap_pc4 got %h exp %h", id_pc_plus4_w, 32'h0); end
        n_vec++; if (id_instr_w !== 32'h4FFF_FFFF) begin n_err++; $display("FAIL wrap_instr got %h exp %h", id_instr_w, 32'h4FFF_FFFF); end
        n_vec++; if (id_valid_w !== 1'b1) begin n_err++; $display("FAIL wrap_valid got %b exp 1", id_valid_w); end
        n_vec++; if (fetch_count_w !== 32'd1) begin n_err++; $display("FAIL wrap_count got %0d exp 1", fetch_count_w); end
    endtask

    initial begin
        rst_w = 1'b1;
        test_reset();
        test_sequential();
        test_stall();
        test_redirect();
        test_flush();
        test_reset_mid();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the byte address loaded into the PC on reset.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, the reset; reset is synchronous and active-high.
REQ-004 The block SHALL have port stall, input, 1, which holds the PC and the IF/ID register.
REQ-005 The block SHALL have port flush, input, 1, which loads a bubble into the IF/ID register.
REQ-006 The block SHALL have port branch_taken, input, 1, the branch redirect request.
REQ-007 The block SHALL have port branch_target, input, 32, the branch byte address.
REQ-008 The block SHALL have port jump_en, input, 1, the jump redirect request.
REQ-009 The block SHALL have port jump_target, input, 32, the jump byte address.
REQ-010 The block SHALL have port imem_addr, output, 32, the word index presented to instruction memory.
REQ-011 The block SHALL have port imem_data, input, 32, the instruction word returned combinationally by instruction memory.
REQ-012 The block SHALL have port pc, output, 32, the current fetch byte address.
REQ-013 The block SHALL have port id_instr, output, 32, the registered instruction for decode.
REQ-014 The block SHALL have port id_pc_plus4, output, 32, the registered PC+4 of id_instr.
REQ-015 The block SHALL have port id_valid, output, 1, which is high when id_instr is a real fetched instruction.
REQ-016 The block SHALL have port fetch_count, output, 32, the count of instructions accepted into IF/ID.

Function
REQ-017 imem_addr SHALL be combinational and equal to {2'b00, pc[31:2]}, so word N of memory holds byte address 4N.
REQ-018 pc_plus4 SHALL be pc + 4, computed modulo 2^32, so 32'hFFFF_FFFC wraps to 32'h0000_0000.
REQ-019 Next-PC priority SHALL be, highest first: jump_en, then branch_taken, then stall, then sequential.
- jump_en: pc <= {jump_target[31:2], 2'b00}.
- branch_taken: pc <= {branch_target[31:2], 2'b00}.
- stall: pc holds.
- otherwise: pc <= pc_plus4.
REQ-020 A redirect (jump_en or branch_taken) SHALL override stall for the PC update.
REQ-021 A redirect SHALL force an IF/ID bubble on the same edge: id_valid <= 0, id_instr <= 32'h0000_0000, id_pc_plus4 <= 0.
REQ-022 flush SHALL produce the same bubble as REQ-021 without affecting the PC update.
REQ-023 flush and a redirect SHALL override stall for the IF/ID register.
REQ-024 With stall=1 and no redirect or flush, id_instr, id_pc_plus4, id_valid and fetch_count SHALL all hold.
REQ-025 With no stall, flush or redirect, the IF/ID register SHALL capture imem_data, pc_plus4 and valid=1 on the same edge the PC advances.
REQ-026 Fetch-to-decode latency SHALL be one cycle.
REQ-027 fetch_count SHALL increment by 1 only on edges where id_valid is loaded with 1, and SHALL wrap from 32'hFFFF_FFFF to 0.
REQ-028 The misaligned low two bits of any target SHALL be dropped silently, with no error output.

Reset
REQ-029 On a rising edge with rst=1 the block SHALL set pc=RESET_PC, id_instr=0, id_pc_plus4=0, id_valid=0 and fetch_count=0.
REQ-030 rst SHALL override stall, flush and redirects.
REQ-031 rst SHALL take effect mid-operation on the next edge.
REQ-032 On the first edge after rst is deasserted, with no stall, the block SHALL fetch the word at RESET_PC.

Verification
REQ-033 Sequential fetch: rst for 2 cycles, then free run with memory word N = 32'h1000_0000+N -> pc = 0,4,8,…; id_instr = 32'h1000_0000, 32'h1000_0001 on successive cycles; id_pc_plus4 = 4,8; fetch_count = 1,2,3.
REQ-034 Stall: stall=1 for 3 cycles at pc=8 -> pc stays 8, id_instr/id_valid/fetch_count unchanged; release -> resumes at 8, then 12.
REQ-035 Redirect priority: jump_en=1 with jump_target=32'h40, branch_taken=1 with branch_target=32'h80, and stall=1 together -> next pc = 32'h40, id_valid=0, id_instr=0, fetch_count unchanged.
REQ-036 Misaligned target: branch_taken with branch_target=32'h0000_0107 -> pc = 32'h0000_0104, imem_addr = 32'h0000_0041.
REQ-037 Wrap: RESET_PC=32'hFFFF_FFFC, free run -> pc goes FFFF_FFFC then 0000_0000; id_pc_plus4 = 0 for the first instruction.
REQ-038 Reset mid-run: assert rst while stall=1 and flush=1 at pc=32'h20 -> next edge pc=RESET_PC, all IF/ID outputs 0, fetch_count=0.
